// File: rtl/program_loader.sv
// Boot-time instruction-memory writer: assembles big-endian words from a byte stream
// and writes them to consecutive addresses from 0, holding the core stalled until loaded.
module program_loader #(
    parameter int unsigned AWL   = 6,
    parameter int unsigned DWL   = 32,
    parameter int unsigned DEPTH = 2 ** AWL
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [AWL:0]   count,
    input  logic           invalid,
    input  logic [7:0]     indata,
    output logic           inready,
    output logic           imwe,
    output logic [AWL-1:0] imwa,
    output logic [DWL-1:0] imwd,
    output logic           busy,
    output logic           done,
    output logic           cpuhold
);

    localparam int unsigned NB  = DWL / 8;
    localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [AWL:0]   MAXN  = DEPTH[AWL:0];
    localparam logic [AWL:0]   WONE  = 1;
    localparam logic [BCW-1:0] BONE  = 1;
    localparam logic [BCW-1:0] LASTB = BCW'(NB - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_t;

    state_t         state_q;
    logic [AWL:0]   n_q;
    logic [AWL:0]   addr_q;
    logic [AWL:0]   word_q;
    logic [BCW-1:0] byte_q;
    logic [DWL-1:0] shreg_q;
    logic           loaded_q;
    logic [DWL-1:0] next_word;

    // Earlier bytes shift toward the MSB, so the first byte ends up on top.
    always_comb begin
        next_word      = shreg_q << 8;
        next_word[7:0] = indata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            n_q      <= '0;
            addr_q   <= '0;
            word_q   <= '0;
            byte_q   <= '0;
            shreg_q  <= '0;
            loaded_q <= 1'b0;
            inready  <= 1'b0;
            imwe     <= 1'b0;
            imwa     <= '0;
            imwd     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        n_q    <= (count > MAXN) ? MAXN : count;
                        addr_q <= '0;
                        word_q <= '0;
                        byte_q <= '0;
                        busy   <= 1'b1;
                        if (count == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q <= StLoad;
                            inready <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (invalid && inready) begin
                        shreg_q <= next_word;
                        if (byte_q == LASTB) begin
                            byte_q  <= '0;
                            state_q <= StWrite;
                            inready <= 1'b0;
                            imwe    <= 1'b1;
                            imwa    <= addr_q[AWL-1:0];
                            imwd    <= next_word;
                        end else begin
                            byte_q <= byte_q + BONE;
                        end
                    end
                end
                StWrite: begin
                    imwe   <= 1'b0;
                    addr_q <= addr_q + WONE;
                    word_q <= word_q + WONE;
                    byte_q <= '0;
                    if (word_q + WONE == n_q) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end else begin
                        state_q <= StLoad;
                        inready <= 1'b1;
                    end
                end
                StDone: begin
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    loaded_q <= 1'b1;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Core stays held until a full load has completed since reset, and during any reload.
    assign cpuhold = ~loaded_q | busy;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a negedge monitor records writes and Done pulses
// into a shadow memory; every comparison goes through one check task.
module tb_program_loader;

    localparam int AWL   = 6;
    localparam int DWL   = 32;
    localparam int DEPTH = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [AWL:0]   count = '0;
    logic           invalid = 1'b0;
    logic [7:0]     indata = '0;
    logic           inready;
    logic           imwe;
    logic [AWL-1:0] imwa;
    logic [DWL-1:0] imwd;
    logic           busy;
    logic           done;
    logic           cpuhold;

    program_loader #(
        .AWL  (AWL),
        .DWL  (DWL),
        .DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .count  (count),
        .invalid(invalid),
        .indata (indata),
        .inready(inready),
        .imwe   (imwe),
        .imwa   (imwa),
        .imwd   (imwd),
        .busy   (busy),
        .done   (done),
        .cpuhold(cpuhold)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int             total = 0;
    int             bad = 0;
    int             wr_cnt, done_cnt, done_cyc, fall_cyc, last_addr, start_cyc;
    logic [DWL-1:0] mem [DEPTH];
    logic           prev_hold = 1'b1;
    logic [7:0]     stream[$];

    always @(negedge clk) begin
        if (imwe) begin
            wr_cnt++;
            mem[imwa] = imwd;
            last_addr = int'(imwa);
        end
        if (done) begin
            done_cnt++;
            done_cyc = edge_n;
        end
        if (prev_hold && !cpuhold) fall_cyc = edge_n;
        prev_hold = cpuhold;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wr_cnt    = 0;
        done_cnt  = 0;
        done_cyc  = -1000;
        fall_cyc  = -1000;
        last_addr = -1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    endtask

    // start_cyc is the edge count during the cycle in which Start is high.
    task automatic kick(input int n);
        @(negedge clk);
        start     = 1'b1;
        count     = (AWL+1)'(n);
        start_cyc = edge_n;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input int stall_after, input int stall_len, input int pulse_at,
                        input int pulse_count);
        for (int i = 0; i < stream.size(); i++) begin
            int guard = 0;
            bit acc = 1'b0;
            if (i == stall_after) begin
                repeat (stall_len) begin
                    @(negedge clk);
                    invalid = 1'b0;
                    @(posedge clk);
                end
            end
            while (!acc && guard < 50) begin
                @(negedge clk);
                invalid = 1'b1;
                indata  = stream[i];
                start   = (i == pulse_at) && (guard == 0);
                if (start) count = (AWL+1)'(pulse_count);
                acc     = inready;
                @(posedge clk);
                guard++;
            end
            if (!acc) check("byte_accept_timeout", 0, 1);
        end
        @(negedge clk);
        invalid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (done_cnt == 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("done_seen", 64'(done_cnt > 0), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        clear_mon();

        // Reset then idle
        repeat (3) begin
            @(negedge clk);
            check("rst_outs", {cpuhold, inready, imwe, busy, done}, 5'b10000);
        end
        check("rst_imwa", imwa, 0);
        check("rst_imwd", imwd, 0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_outs", {cpuhold, inready, imwe, busy, done}, 5'b10000);
        end

        // Two-word load, no stalls
        clear_mon();
        stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        kick(2);
        send(-1, 0, -1, 0);
        wait_done();
        check("w2_writes", wr_cnt, 2);
        check("w2_mem0", mem[0], 32'h12345678);
        check("w2_mem1", mem[1], 32'h9ABCDEF0);
        check("w2_done_lat", done_cyc - start_cyc, 11);
        check("w2_hold_fall", fall_cyc - done_cyc, 1);
        check("w2_done_cnt", done_cnt, 1);
        check("w2_imwa_hold", imwa, 1);
        check("w2_imwd_hold", imwd, 32'h9ABCDEF0);
        check("w2_cpuhold", cpuhold, 0);

        // Stalled stream: 5 idle cycles before the third byte
        clear_mon();
        stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        kick(1);
        send(2, 5, -1, 0);
        wait_done();
        check("stall_writes", wr_cnt, 1);
        check("stall_mem0", mem[0], 32'hAABBCCDD);
        check("stall_done_lat", done_cyc - start_cyc, 6 + 5);

        // Count = 0
        clear_mon();
        kick(0);
        wait_done();
        check("n0_writes", wr_cnt, 0);
        check("n0_done_lat", done_cyc - start_cyc, 1);
        check("n0_done_cnt", done_cnt, 1);

        // Count = DEPTH+1 clamps to DEPTH
        clear_mon();
        stream.delete();
        for (int i = 0; i < DEPTH * 4; i++) stream.push_back(8'(i));
        kick(DEPTH + 1);
        send(-1, 0, -1, 0);
        wait_done();
        check("full_writes", wr_cnt, DEPTH);
        check("full_last_addr", last_addr, DEPTH - 1);
        check("full_mem0", mem[0], 32'h00010203);
        check("full_mem_last", mem[DEPTH-1], 32'hFCFDFEFF);
        check("full_done_lat", done_cyc - start_cyc, 1 + DEPTH * 5);

        // Reset mid-load: after two bytes of word 1
        clear_mon();
        stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        kick(3);
        send(-1, 0, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outs", {cpuhold, inready, imwe, busy, done}, 5'b10000);
        check("mid_rst_imwa", imwa, 0);
        check("mid_rst_imwd", imwd, 0);
        check("mid_rst_writes", wr_cnt, 1);
        check("mid_rst_mem0", mem[0], 32'h01020304);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_hold", cpuhold, 1);
        check("post_rst_writes", wr_cnt, 1);
        clear_mon();
        stream = '{8'h11, 8'h22, 8'h33, 8'h44};
        kick(1);
        send(-1, 0, -1, 0);
        wait_done();
        check("reload_writes", wr_cnt, 1);
        check("reload_addr", last_addr, 0);
        check("reload_mem0", mem[0], 32'h11223344);
        check("reload_cpuhold", cpuhold, 0);

        // Start while busy is ignored
        clear_mon();
        stream = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7};
        kick(2);
        send(-1, 0, 1, 5);
        wait_done();
        repeat (40) @(negedge clk);
        check("busy_start_writes", wr_cnt, 2);
        check("busy_start_done_cnt", done_cnt, 1);
        check("busy_start_mem1", mem[1], 32'hC4C5C6C7);
        check("busy_start_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
